// File: rtl/midi_in_if.sv
// MIDI input bundle: the serial line in, decoded channel messages and real-time bytes out.
interface midi_in_if;
    logic       midi_rx;
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       msg_valid;
    logic [7:0] rt_byte;
    logic       rt_valid;
    logic       frame_err;

    modport master (
        output midi_rx,
        input  status, data1, data2, msg_valid, rt_byte, rt_valid, frame_err
    );
    modport slave (
        input  midi_rx,
        output status, data1, data2, msg_valid, rt_byte, rt_valid, frame_err
    );
endinterface

// File: rtl/midi_in.sv
// MIDI receiver: oversampled 8N1 byte receiver followed by a running-status
// channel message parser with real-time byte bypass.
module midi_in #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 31250,
    parameter int OVS    = 16
) (
    input  logic      clk,
    input  logic      rst,
    midi_in_if.slave  bus
);
    localparam int DIV = CLK_HZ / (BAUD * OVS);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = (OVS > 2) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    rx_state_t     state, state_nx;
    logic          rx_s1, rx_s2, rx_prev;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick, fall, half_hit, full_hit;
    logic          byte_rdy, stop_bad;

    logic [7:0]    run_status;
    logic          has_status, have_d1;
    logic [7:0]    d1_hold;
    logic          one_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.midi_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall = rx_prev & ~rx_s2;
    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    assign half_hit = tick && (tick_cnt == TW'(OVS / 2 - 1));
    assign full_hit = tick && (tick_cnt == TW'(OVS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (fall)                     state_nx = START;
            START:     if (half_hit)                 state_nx = rx_s2 ? IDLE : DATA;
            DATA:      if (full_hit && bit_cnt == 3'd7) state_nx = STOP;
            STOP:      if (full_hit)                 state_nx = rx_s2 ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s2)                    state_nx = IDLE;
            default:                                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_rdy = 1'b0;
        stop_bad = 1'b0;
        if (state == STOP && full_hit) begin
            byte_rdy = rx_s2;
            stop_bad = ~rx_s2;
        end
    end

    // tick_cnt restarts at each sample point so the next sample lands mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if ((state == START && half_hit) || full_hit) begin
            tick_cnt <= '0;
            if (state == DATA) begin
                shreg   <= {rx_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign one_data = (run_status[7:5] == 3'b110);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.status    <= '0;
            bus.data1     <= '0;
            bus.data2     <= '0;
            bus.msg_valid <= 1'b0;
            bus.rt_byte   <= '0;
            bus.rt_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            run_status    <= '0;
            has_status    <= 1'b0;
            have_d1       <= 1'b0;
            d1_hold       <= '0;
        end else begin
            bus.msg_valid <= 1'b0;
            bus.rt_valid  <= 1'b0;
            bus.frame_err <= stop_bad;
            if (byte_rdy) begin
                if (shreg >= 8'hF8) begin
                    bus.rt_byte  <= shreg;
                    bus.rt_valid <= 1'b1;
                end else if (shreg >= 8'hF0) begin
                    has_status <= 1'b0;
                    have_d1    <= 1'b0;
                end else if (shreg[7]) begin
                    run_status <= shreg;
                    has_status <= 1'b1;
                    have_d1    <= 1'b0;
                end else if (has_status) begin
                    if (one_data || have_d1) begin
                        bus.status    <= run_status;
                        bus.data1     <= one_data ? shreg : d1_hold;
                        bus.data2     <= one_data ? 8'h00 : shreg;
                        bus.msg_valid <= 1'b1;
                        have_d1       <= 1'b0;
                    end else begin
                        d1_hold <= shreg;
                        have_d1 <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_in.sv
// Bench for midi_in: directed vector table, reset/glitch corner sequences and
// a randomized byte stream checked against a queue-based message model.
module tb_midi_in;
    localparam int CLK_HZ = 1500000;
    localparam int BAUD   = 31250;
    localparam int OVS    = 16;
    localparam int DIV    = CLK_HZ / (BAUD * OVS);
    localparam int BIT    = DIV * OVS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    midi_in_if bus();

    midi_in #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- observation ----------------
    int          cyc = 0;
    int          stop_at = 0;
    logic [23:0] got_msg[$];
    logic [7:0]  got_rt[$];
    int          got_fe = 0, lat_bad = 0, wide = 0;
    logic        mv_q = 1'b0, rv_q = 1'b0, fe_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit late_ok(input int dt);
        return (dt >= BIT / 2 - 1) && (dt <= BIT / 2 + DIV + 2);
    endfunction

    always @(negedge clk) begin
        if (bus.msg_valid) begin
            got_msg.push_back({bus.status, bus.data1, bus.data2});
            if (!late_ok(cyc - stop_at)) lat_bad++;
        end
        if (bus.rt_valid) begin
            got_rt.push_back(bus.rt_byte);
            if (!late_ok(cyc - stop_at)) lat_bad++;
        end
        if (bus.frame_err) begin
            got_fe++;
            if (!late_ok(cyc - stop_at)) lat_bad++;
        end
        if ((bus.msg_valid && mv_q) || (bus.rt_valid && rv_q) || (bus.frame_err && fe_q)) wide++;
        mv_q <= bus.msg_valid;
        rv_q <= bus.rt_valid;
        fe_q <= bus.frame_err;
    end

    // ---------------- reference model ----------------
    int          rs = -1;
    logic [7:0]  pend[$];
    logic [23:0] exp_msg[$];
    logic [7:0]  exp_rt[$];
    int          exp_fe = 0;

    function automatic void model_byte(input logic [7:0] b);
        int need;
        logic [7:0] d2;
        if (b >= 8'hF8) exp_rt.push_back(b);
        else if (b >= 8'hF0) begin rs = -1; pend.delete(); end
        else if (b >= 8'h80) begin rs = int'(b); pend.delete(); end
        else if (rs >= 0) begin
            pend.push_back(b);
            need = (rs >= 'hC0 && rs <= 'hDF) ? 1 : 2;
            if (pend.size() == need) begin
                d2 = (need == 2) ? pend[1] : 8'h00;
                exp_msg.push_back({rs[7:0], pend[0], d2});
                pend.delete();
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        bus.midi_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.midi_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        bus.midi_rx = good_stop;
        stop_at = cyc;
        repeat (BIT) @(negedge clk);
        if (!good_stop) begin
            bus.midi_rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        if (good_stop) model_byte(b);
        else exp_fe++;
    endtask

    task automatic do_reset();
        bus.midi_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        got_msg.delete(); got_rt.delete();
        got_fe = 0; lat_bad = 0; wide = 0;
        rs = -1; pend.delete(); exp_msg.delete(); exp_rt.delete(); exp_fe = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " status"},    int'(bus.status),    0);
        check({tag, " data1"},     int'(bus.data1),     0);
        check({tag, " data2"},     int'(bus.data2),     0);
        check({tag, " rt_byte"},   int'(bus.rt_byte),   0);
        check({tag, " msg_valid"}, int'(bus.msg_valid), 0);
        check({tag, " rt_valid"},  int'(bus.rt_valid),  0);
        check({tag, " frame_err"}, int'(bus.frame_err), 0);
    endtask

    task automatic compare_streams(input string tag);
        check({tag, " msg count"}, got_msg.size(), exp_msg.size());
        for (int i = 0; i < got_msg.size() && i < exp_msg.size(); i++)
            check({tag, " msg"}, int'(got_msg[i]), int'(exp_msg[i]));
        check({tag, " rt count"}, got_rt.size(), exp_rt.size());
        for (int i = 0; i < got_rt.size() && i < exp_rt.size(); i++)
            check({tag, " rt"}, int'(got_rt[i]), int'(exp_rt[i]));
        check({tag, " frame_err count"}, got_fe, exp_fe);
        check({tag, " pulse latency"}, lat_bad, 0);
        check({tag, " pulse width"}, wide, 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int              n;
        logic [0:4][7:0] by;
        logic [0:4]      bad;
        int              n_msg;
        logic [7:0]      st, d1, d2;
        int              n_rt;
        logic [7:0]      rt;
        int              n_fe;
    } vec_t;

    localparam int NV = 8;
    vec_t vec[NV];

    initial begin
        #1_900_000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        bit         ok;

        vec[0] = '{3, 40'h903C640000, 5'b00000, 1, 8'h90, 8'h3C, 8'h64, 0, 8'h00, 0};
        vec[1] = '{5, 40'h903C644000, 5'b00000, 2, 8'h90, 8'h40, 8'h00, 0, 8'h00, 0};
        vec[2] = '{2, 40'hC507000000, 5'b00000, 1, 8'hC5, 8'h07, 8'h00, 0, 8'h00, 0};
        vec[3] = '{4, 40'h903CF86400, 5'b00000, 1, 8'h90, 8'h3C, 8'h64, 1, 8'hF8, 0};
        vec[4] = '{4, 40'h5580102000, 5'b10000, 1, 8'h80, 8'h10, 8'h20, 0, 8'h00, 1};
        vec[5] = '{5, 40'h3C90F03C64, 5'b00000, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0};
        vec[6] = '{5, 40'h903C914050, 5'b00000, 1, 8'h91, 8'h40, 8'h50, 0, 8'h00, 0};
        vec[7] = '{3, 40'hD07F7F0000, 5'b00000, 2, 8'hD0, 8'h7F, 8'h00, 0, 8'h00, 0};

        bus.midi_rx = 1'b1;
        @(negedge clk);
        check_zero("reset");

        for (int v = 0; v < NV; v++) begin
            do_reset();
            for (int i = 0; i < vec[v].n; i++) send_byte(vec[v].by[i], !vec[v].bad[i]);
            repeat (BIT) @(negedge clk);
            check($sformatf("vec%0d n_msg", v),   got_msg.size(),     vec[v].n_msg);
            check($sformatf("vec%0d status", v),  int'(bus.status),   int'(vec[v].st));
            check($sformatf("vec%0d data1", v),   int'(bus.data1),    int'(vec[v].d1));
            check($sformatf("vec%0d data2", v),   int'(bus.data2),    int'(vec[v].d2));
            check($sformatf("vec%0d n_rt", v),    got_rt.size(),      vec[v].n_rt);
            check($sformatf("vec%0d rt_byte", v), int'(bus.rt_byte),  int'(vec[v].rt));
            check($sformatf("vec%0d n_fe", v),    got_fe,             vec[v].n_fe);
            compare_streams($sformatf("vec%0d", v));
        end

        // idle-line glitch, then reset in the middle of 0x90
        do_reset();
        bus.midi_rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        bus.midi_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        b = 8'h90;
        bus.midi_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.midi_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rst = 1'b1;
        bus.midi_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("mid-byte reset");
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check("glitch/abort msgs", got_msg.size(), 0);
        check("glitch/abort rt",   got_rt.size(),  0);
        check("glitch/abort fe",   got_fe,         0);
        check_zero("after abort");

        // reception resumes after the aborted byte
        send_byte(8'hC5, 1'b1);
        send_byte(8'h07, 1'b1);
        repeat (BIT) @(negedge clk);
        check("resume n_msg",  got_msg.size(),  1);
        check("resume status", int'(bus.status), 'hC5);
        check("resume data1",  int'(bus.data1),  'h07);

        // asynchronous clear: sampled before the next rising edge
        rst = 1'b1;
        #1;
        check("async status", int'(bus.status), 0);
        check("async data1",  int'(bus.data1),  0);
        @(negedge clk);

        // randomized stream against the model
        do_reset();
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 99);
            ok = 1'b1;
            if (r < 50)      b = 8'($urandom_range(0, 127));
            else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 85) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 90) b = 8'($urandom_range(8'hF0, 8'hF7));
            else begin
                b  = 8'($urandom_range(0, 255));
                ok = 1'b0;
            end
            send_byte(b, ok);
            repeat ($urandom_range(0, BIT)) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
        compare_streams("random");
        if (exp_msg.size() > 0)
            check("random hold", int'({bus.status, bus.data1, bus.data2}),
                  int'(exp_msg[exp_msg.size() - 1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/midi_in.md
MIDI_IN -- requirements
Module: midi_in

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI bit rate.
REQ-003 SHALL have parameter OVS, default 16, oversampling ticks per bit.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port midi_rx  input  1  serial MIDI line, idle high, asynchronous to clk.
REQ-007 SHALL have port status  output  8  status byte of the last completed channel message.
REQ-008 SHALL have port data1  output  8  first data byte of the last completed message.
REQ-009 SHALL have port data2  output  8  second data byte; 0 for one-data-byte messages.
REQ-010 SHALL have port msg_valid  output  1  one-cycle pulse when status/data1/data2 update.
REQ-011 SHALL have port rt_byte  output  8  last received real-time byte (0xF8-0xFF).
REQ-012 SHALL have port rt_valid  output  1  one-cycle pulse when rt_byte updates.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a missing stop bit.

Function
REQ-014 SHALL synchronise midi_rx through two flip-flops, reset to 1, before any use.
REQ-015 SHALL generate a tick every DIV = CLK_HZ/(BAUD*OVS) clk cycles (integer division; 100 at defaults) from a free-running counter reset to 0.
REQ-016 SHALL implement byte receiver states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-017 IDLE: synchronised falling edge -> START, tick count cleared.
REQ-018 START: after OVS/2 ticks sample line; low -> DATA, high -> IDLE (glitch rejected, nothing reported).
REQ-019 DATA: sample every OVS ticks, 8 bits, LSB first, shifted into byte register.
REQ-020 STOP: after OVS ticks sample; high -> byte accepted, pulse internal byte_rdy 1 cycle, -> IDLE; low -> pulse frame_err, discard byte, -> WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until synchronised line is high, then -> IDLE.
REQ-022 Parser: byte 0xF8-0xFF SHALL pulse rt_valid with rt_byte = byte the cycle after byte_rdy, leaving running status and partial message untouched.
REQ-023 Byte 0x80-0xEF SHALL set running status, clear data count; expected data bytes = 1 for 0xC0-0xDF, else 2.
REQ-024 Byte 0xF0-0xF7 SHALL clear running status and any partial message; no output.
REQ-025 Data byte (bit7=0) with no running status SHALL be dropped.
REQ-026 Data byte completing expected count SHALL load status/data1/data2 and pulse msg_valid the cycle after byte_rdy; running status retained, count cleared for next message.
REQ-027 Message latency: msg_valid SHALL assert 1 clk after the final stop-bit sample.
REQ-028 status/data1/data2/rt_byte SHALL hold their values between pulses.
REQ-029 Partial message followed by a new channel status SHALL be discarded silently.
REQ-030 A new start edge SHALL be accepted in the cycle the receiver returns to IDLE (back-to-back bytes, no gap).

Reset
REQ-031 On rst high, asynchronously: status, data1, data2, rt_byte = 0x00; msg_valid, rt_valid, frame_err = 0; receiver state IDLE; sync flops = 1; running status cleared; counters = 0.
REQ-032 rst asserted mid-byte SHALL abort the byte with no pulse; after release, reception resumes on the next falling edge.

Verification
REQ-033 Send 0x90,0x3C,0x64 at 31250 baud -> one msg_valid; status=0x90, data1=0x3C, data2=0x64.
REQ-034 Send 0x90,0x3C,0x64,0x40,0x00 -> second msg_valid with status=0x90, data1=0x40, data2=0x00 (running status).
REQ-035 Send 0xC5,0x07 -> msg_valid; status=0xC5, data1=0x07, data2=0x00.
REQ-036 Send 0x90,0x3C,0xF8,0x64 -> rt_valid with rt_byte=0xF8, then msg_valid with 0x90/0x3C/0x64.
REQ-037 Send byte 0x55 with stop bit low, then 0x80,0x10,0x20 -> frame_err pulse once, no msg_valid for 0x55, then msg_valid 0x80/0x10/0x20.
REQ-038 Low glitch of 4 ticks on idle line, then rst pulse mid-byte of 0x90 -> no outputs pulse; all outputs at reset values.
